ets_sweep_sequencer: RTL
========================

// Module: ets_sweep_sequencer
//
// PURPOSE
// Runs an equivalent-time phase sweep with no per-step SPI traffic. For each step it:
//   programs the ETS clock generator's timing control, pulses its reset and waits for lock;
//   fires one offset-sampler run, captures the result and presents it on a valid/ready stream.
// Sits between the register file (config, start/abort) and the clkgen/sampler pair.
// Its stream output feeds the result FIFO drained over SPI.
//
// PARAMETERS
// STEP_WIDTH    16         width of step count and step index
// RESET_CYCLES  8          cycles clk_reset_req is held high per retune (>=1)
// SETTLE_CYCLES 16         wait after lock before run_req (0 = none)
// LOCK_TIMEOUT  1000000    max cycles in WAIT_LOCK before error
//
// PORTS
// clk              in   1           system clock
// reset            in   1           asynchronous, active-high reset
// start            in   1           1-cycle pulse: latch config, begin sweep
// abort            in   1           1-cycle pulse: stop sweep
// phase_start      in   32          timing_control for step 0
// phase_step       in   32          per-step timing_control increment
// num_steps        in   STEP_WIDTH  steps to run
// timing_control   out  32          to clkgen timing-control input
// clk_reset_req    out  1           to clkgen reset
// clk_locked       in   1           clkgen lock (asynchronous; 2-flop synced inside)
// run_req          out  1           1-cycle pulse to sampler request_run
// result_ready     in   1           sampler result-valid level
// sampler_result   in   32          sampler result word
// sample_valid     out  1           stream valid
// sample_data      out  32          captured result
// sample_index     out  STEP_WIDTH  step index of sample_data
// sample_ready     in   1           stream ready
// busy             out  1           high in any state except IDLE
// done             out  1           1-cycle pulse: sweep completed normally
// error            out  1           sticky: lock timeout; cleared by next accepted start
//
// BEHAVIOUR
// - Reset: state IDLE, all outputs 0, including timing_control, counters and error.
// - States:
//   IDLE -> RETUNE on start; captures phase_start/phase_step/num_steps; step k=0.
//   IDLE -> DONE if num_steps==0: done pulses 1 cycle later, no run, timing_control unchanged.
//   start is ignored when not IDLE.
// - RETUNE
//   - timing_control <= phase_start + k*phase_step (running 32-bit sum, wraps mod 2^32).
//   - clk_reset_req high exactly RESET_CYCLES cycles.
//   - Then -> WAIT_LOCK.
// - WAIT_LOCK: synced lock high -> SETTLE; LOCK_TIMEOUT cycles without it -> ERROR.
// - SETTLE: count SETTLE_CYCLES, then -> RUN.
// - RUN: run_req=1 for one cycle -> WAIT_RESULT.
// - WAIT_RESULT
//   - captures sampler_result on the rising edge of result_ready (registered prev value).
//   - a level already high on entry is not accepted; stale results cannot complete a step.
//   - No timeout here.
// - EMIT
//   - sample_valid=1, sample_data/sample_index=k stay stable until sample_valid&&sample_ready.
//   - Then k+1==num_steps -> DONE, else k++ -> RETUNE.
//   - Ready asserted with valid transfers that cycle; valid falls the next cycle.
// - DONE: done=1 one cycle -> IDLE. ERROR: error<=1 (sticky) -> IDLE; done not pulsed.
// - abort: any state -> IDLE next cycle.
//   - clears run_req/clk_reset_req/sample_valid, no done, timing_control holds.
//   - abort wins over a simultaneous start; if a transfer completes that same cycle, it counts.
// - Reset mid-sweep: immediate return to reset values, including clk_reset_req=0.
// - run_req is never asserted unless synced lock was high on entry to SETTLE.
//
// TESTING
// - start, phase_start=0x100, phase_step=0x10, num_steps=3, lock 4 cyc after reset drop,
//   ready=1 -> timing_control 0x100/0x110/0x120; 3 run_req pulses;
//   samples idx 0,1,2 in order; one done pulse.
// - num_steps=0 -> done 1 cycle after start, no run_req/clk_reset_req, timing_control=0.
// - hold clk_locked=0 (LOCK_TIMEOUT=64 in bench) -> error=1 after 64 cyc in WAIT_LOCK, busy=0,
//   no done; next start clears error.
// - sample_ready low 10 cyc during EMIT -> sample_valid/data/index stable; no next RETUNE until
//   accepted.
// - abort in WAIT_RESULT, then result_ready rises -> IDLE, nothing emitted; fresh start runs
//   from step 0.
// - phase_start=0xFFFFFFF0, phase_step=0x10, num_steps=2 -> timing_control 0xFFFFFFF0 then 0x0.

Source files
------------

// File: rtl/ets_sweep_sequencer_if.sv
// Result stream between the sweep sequencer and the result FIFO.
//   sample_valid  : result word available
//   sample_data   : captured sampler result
//   sample_index  : sweep step index of sample_data
//   sample_ready  : consumer accepts when high together with sample_valid
interface ets_sweep_sequencer_if #(
    parameter int unsigned STEP_WIDTH = 16
);
    logic                  sample_valid;
    logic [31:0]           sample_data;
    logic [STEP_WIDTH-1:0] sample_index;
    logic                  sample_ready;

    modport master (
        output sample_valid,
        output sample_data,
        output sample_index,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  sample_data,
        input  sample_index,
        output sample_ready
    );
endinterface

// File: rtl/ets_sweep_sequencer.sv
// Equivalent-time phase sweep sequencer. Each step retunes the ETS clock
// generator (timing_control + reset pulse + wait for lock), fires one sampler
// run and streams the captured result out with its step index.
//   clk, reset         : system clock, asynchronous active-high reset
//   start, abort       : 1-cycle control pulses from the register file
//   phase_start/_step  : timing_control of step 0 and per-step increment
//   num_steps          : number of steps in the sweep
//   timing_control,
//   clk_reset_req,
//   clk_locked         : clock generator control / lock (lock is async)
//   run_req,
//   result_ready,
//   sampler_result     : sampler handshake
//   stream             : valid/ready result stream (master side)
//   busy, done, error  : status (error is sticky until the next start)
module ets_sweep_sequencer #(
    parameter int unsigned STEP_WIDTH    = 16,
    parameter int unsigned RESET_CYCLES  = 8,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT  = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [31:0]           phase_start,
    input  logic [31:0]           phase_step,
    input  logic [STEP_WIDTH-1:0] num_steps,
    output logic [31:0]           timing_control,
    output logic                  clk_reset_req,
    input  logic                  clk_locked,
    output logic                  run_req,
    input  logic                  result_ready,
    input  logic [31:0]           sampler_result,
    ets_sweep_sequencer_if.master stream,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned CNT_MAX0 = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CNT_MAX  = (CNT_MAX0 > LOCK_TIMEOUT) ? CNT_MAX0 : LOCK_TIMEOUT;
    localparam int unsigned CNT_W    = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    typedef enum logic [3:0] {
        S_IDLE, S_RETUNE, S_WAIT_LOCK, S_SETTLE, S_RUN,
        S_WAIT_RESULT, S_EMIT, S_DONE, S_ERROR
    } state_t;

    state_t                state, state_next;
    logic [CNT_W-1:0]      cnt;
    logic                  lock_meta, lock_s;
    logic                  rr_prev;
    logic [31:0]           step_q;
    logic [STEP_WIDTH-1:0] num_q;
    logic [STEP_WIDTH-1:0] k;
    logic                  last;
    logic                  sample_valid_q;
    logic [31:0]           sample_data_q;
    logic [STEP_WIDTH-1:0] sample_index_q;

    assign stream.sample_valid = sample_valid_q;
    assign stream.sample_data  = sample_data_q;
    assign stream.sample_index = sample_index_q;

    // Next-state decode; abort overrides every transition
    always_comb begin
        state_next = state;
        last       = (STEP_WIDTH'(k + STEP_WIDTH'(1)) == num_q);
        case (state)
            S_IDLE:
                if (start)
                    state_next = (num_steps == '0) ? S_DONE : S_RETUNE;
            S_RETUNE:
                if (cnt == CNT_W'(RESET_CYCLES - 1))
                    state_next = S_WAIT_LOCK;
            S_WAIT_LOCK:
                if (lock_s)
                    state_next = (SETTLE_CYCLES == 0) ? S_RUN : S_SETTLE;
                else if (cnt == CNT_W'(LOCK_TIMEOUT - 1))
                    state_next = S_ERROR;
            S_SETTLE:
                if (cnt == CNT_W'(SETTLE_CYCLES - 1))
                    state_next = S_RUN;
            S_RUN:
                state_next = S_WAIT_RESULT;
            // Only a fresh rising edge completes a step; a level left high is stale
            S_WAIT_RESULT:
                if (result_ready && !rr_prev)
                    state_next = S_EMIT;
            S_EMIT:
                if (stream.sample_ready)
                    state_next = last ? S_DONE : S_RETUNE;
            S_DONE:  state_next = S_IDLE;
            S_ERROR: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (abort)
            state_next = S_IDLE;
    end

    // State, datapath and registered outputs (decoded from next state)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= S_IDLE;
            cnt            <= '0;
            lock_meta      <= 1'b0;
            lock_s         <= 1'b0;
            rr_prev        <= 1'b0;
            step_q         <= '0;
            num_q          <= '0;
            k              <= '0;
            timing_control <= '0;
            clk_reset_req  <= 1'b0;
            run_req        <= 1'b0;
            sample_valid_q <= 1'b0;
            sample_data_q  <= '0;
            sample_index_q <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= (state_next != state) ? '0 : CNT_W'(cnt + CNT_W'(1));
            lock_meta <= clk_locked;
            lock_s    <= lock_meta;
            rr_prev   <= result_ready;

            if (state == S_IDLE && state_next != S_IDLE) begin
                step_q <= phase_step;
                num_q  <= num_steps;
                k      <= '0;
                error  <= 1'b0;
                if (state_next == S_RETUNE)
                    timing_control <= phase_start;
            end

            // Running sum keeps the per-step phase free of a multiplier
            if (state == S_EMIT && state_next == S_RETUNE) begin
                k              <= STEP_WIDTH'(k + STEP_WIDTH'(1));
                timing_control <= timing_control + step_q;
            end

            if (state == S_WAIT_RESULT && state_next == S_EMIT) begin
                sample_data_q  <= sampler_result;
                sample_index_q <= k;
            end

            if (state_next == S_ERROR)
                error <= 1'b1;

            clk_reset_req  <= (state_next == S_RETUNE);
            run_req        <= (state_next == S_RUN);
            sample_valid_q <= (state_next == S_EMIT);
            done           <= (state_next == S_DONE);
            busy           <= (state_next != S_IDLE);
        end
    end

endmodule
